// File: rtl/i_type_pkg.sv
// rtl/i_type_pkg.sv - shared states and encodings for the I-type register-file sequencer
package i_type_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CAPT  = 2'd2,
        WRITE = 2'd3
    } seq_state_t;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SLTI  = 3'b010;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_XORI  = 3'b100;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ANDI  = 3'b111;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_SRA  = 7'b0100000;

endpackage

// File: rtl/i_type_alu.sv
// rtl/i_type_alu.sv - combinational I-type ALU with encoding legality check
module i_type_alu
    import i_type_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] operand,
    input  logic [11:0]     imm,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result,
    output logic            legal
);

    logic [XLEN-1:0] imm_ext;
    logic [6:0]      funct7;
    logic [4:0]      shamt;

    assign imm_ext = {{(XLEN-12){imm[11]}}, imm};
    assign funct7  = imm[11:5];
    assign shamt   = imm[4:0];

    // Operation select; shifts are only legal with the exact funct7 patterns
    always_comb begin
        result = '0;
        legal  = 1'b1;
        case (funct3)
            F3_ADDI:  result = operand + imm_ext;
            F3_SLTI:  result = {{(XLEN-1){1'b0}}, ($signed(operand) < $signed(imm_ext))};
            F3_SLTIU: result = {{(XLEN-1){1'b0}}, (operand < imm_ext)};
            F3_XORI:  result = operand ^ imm_ext;
            F3_ORI:   result = operand | imm_ext;
            F3_ANDI:  result = operand & imm_ext;
            F3_SLLI: begin
                result = operand << shamt;
                legal  = (funct7 == FUNCT7_ZERO);
            end
            F3_SRXI: begin
                if (funct7 == FUNCT7_ZERO) begin
                    result = operand >> shamt;
                end else if (funct7 == FUNCT7_SRA) begin
                    result = $unsigned($signed(operand) >>> shamt);
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/i_type_rf_sequencer.sv
// rtl/i_type_rf_sequencer.sv - reads rs1, runs the I-type ALU and writes rd through a single-port register file
module i_type_rf_sequencer
    import i_type_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rd,
    input  logic [11:0]     imm,
    input  logic [2:0]      funct3,
    output logic [AW-1:0]   rf_address,
    output logic            rf_write,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    seq_state_t      state, next_state;
    logic [AW-1:0]   rs1_q, rd_q;
    logic [11:0]     imm_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] result_q;
    logic            done_q, illegal_q;
    logic [XLEN-1:0] alu_result;
    logic            alu_legal;
    logic            retire_from_capt;

    i_type_alu #(.XLEN(XLEN)) u_alu (
        .operand (rf_rdata),
        .imm     (imm_q),
        .funct3  (funct3_q),
        .result  (alu_result),
        .legal   (alu_legal)
    );

    // Instructions that skip the write cycle retire straight out of CAPT
    assign retire_from_capt = !alu_legal || (rd_q == '0);

    // State, latched instruction fields and retirement status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rs1_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            funct3_q  <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (state == IDLE && req_valid) begin
                rs1_q    <= rs1;
                rd_q     <= rd;
                imm_q    <= imm;
                funct3_q <= funct3;
            end
            if (state == CAPT) begin
                if (alu_legal) begin
                    result_q <= alu_result;
                end
                done_q    <= retire_from_capt;
                illegal_q <= !alu_legal;
            end
            if (state == WRITE) begin
                done_q <= 1'b1;
            end
        end
    end

    // Next state and register-file drive; outputs decode state so reset drops rf_write at once
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rf_address = '0;
        rf_write   = 1'b0;
        rf_wdata   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = READ;
            end
            READ: begin
                rf_address = rs1_q;
                next_state = CAPT;
            end
            CAPT: begin
                next_state = retire_from_capt ? IDLE : WRITE;
            end
            WRITE: begin
                rf_address = rd_q;
                rf_write   = 1'b1;
                rf_wdata   = result_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign done    = done_q;
    assign illegal = illegal_q;
    assign result  = result_q;

endmodule

// File: tb/tb_i_type_rf_sequencer.sv
// tb/tb_i_type_rf_sequencer.sv - scoreboard bench for the I-type register-file sequencer
module tb_i_type_rf_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rd = '0;
    logic [11:0] imm = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rf_address;
    logic        rf_write;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata = '0;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    logic [31:0] mem [32];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct { logic [31:0] res; logic ill; int lat; int acc; } done_exp_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; int acc; } wr_exp_t;
    done_exp_t dq[$];
    wr_exp_t   wq[$];

    i_type_rf_sequencer #(.XLEN(32), .AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .rs1        (rs1),
        .rd         (rd),
        .imm        (imm),
        .funct3     (funct3),
        .rf_address (rf_address),
        .rf_write   (rf_write),
        .rf_wdata   (rf_wdata),
        .rf_rdata   (rf_rdata),
        .done       (done),
        .result     (result),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rf_write) mem[rf_address] <= rf_wdata;
        rf_rdata <= mem[rf_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes or retires
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_write) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_addr", {27'd0, rf_address}, 32'hFFFF_FFFF);
                end else begin
                    wr_exp_t w;
                    w = wq.pop_front();
                    chk("write_addr", {27'd0, rf_address}, {27'd0, w.addr});
                    chk("write_data", rf_wdata, w.data);
                    chk("write_cycle", cyc, w.acc + 2);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_exp_t d;
                    d = dq.pop_front();
                    chk("done_result", result, d.res);
                    chk("done_illegal", {31'd0, illegal}, {31'd0, d.ill});
                    chk("done_cycle", cyc, d.acc + d.lat - 1);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] s1, input logic [4:0] d, input logic [11:0] im,
                         input logic [2:0] f3, input logic [31:0] exp_res, input logic exp_ill);
        int n;
        done_exp_t de;
        wr_exp_t   we;
        @(negedge clk);
        req_valid = 1'b1;
        rs1 = s1; rd = d; imm = im; funct3 = f3;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        de.res = exp_res;
        de.ill = exp_ill;
        de.lat = (exp_ill || d == 5'd0) ? 3 : 4;
        de.acc = cyc + 1;
        dq.push_back(de);
        if (!exp_ill && d != 5'd0) begin
            we.addr = d;
            we.data = exp_res;
            we.acc  = cyc + 1;
            wq.push_back(we);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rs1 = 5'd31; rd = 5'd31; imm = 12'hABC; funct3 = 3'b111;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((dq.size() != 0 || wq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done_queue", dq.size(), 0);
        chk("drain_write_queue", wq.size(), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = 32'hA5A5_A5A5;
        mem[1]  = 32'h0000_0005;
        mem[3]  = 32'h8000_0000;
        mem[5]  = 32'hFFFF_FFFF;
        mem[15] = 32'h0000_DEAD;

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
        chk("rst_rf_address", {27'd0, rf_address}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(5'd1, 5'd2,  12'hFFD, 3'b000, 32'h0000_0002, 1'b0);
        issue(5'd3, 5'd4,  12'h41F, 3'b101, 32'hFFFF_FFFF, 1'b0);
        issue(5'd3, 5'd4,  12'h01F, 3'b101, 32'h0000_0001, 1'b0);
        issue(5'd5, 5'd6,  12'h001, 3'b010, 32'h0000_0001, 1'b0);
        issue(5'd5, 5'd7,  12'h001, 3'b011, 32'h0000_0000, 1'b0);
        issue(5'd1, 5'd0,  12'h123, 3'b000, 32'h0000_0128, 1'b0);
        issue(5'd1, 5'd8,  12'h420, 3'b001, 32'h0000_0128, 1'b1);
        issue(5'd1, 5'd9,  12'hFFF, 3'b100, 32'hFFFF_FFFA, 1'b0);
        issue(5'd3, 5'd10, 12'h00F, 3'b110, 32'h8000_000F, 1'b0);
        issue(5'd5, 5'd11, 12'h7F0, 3'b111, 32'h0000_07F0, 1'b0);
        issue(5'd1, 5'd12, 12'h004, 3'b001, 32'h0000_0050, 1'b0);
        issue(5'd1, 5'd12, 12'h21F, 3'b101, 32'h0000_0050, 1'b1);
        issue(5'd5, 5'd13, 12'h001, 3'b000, 32'h0000_0000, 1'b0);
        issue(5'd2, 5'd14, 12'h000, 3'b000, 32'h0000_0002, 1'b0);
        drain();

        chk("mem_x0_untouched", mem[0], 32'hA5A5_A5A5);
        chk("mem_x4", mem[4], 32'h0000_0001);
        chk("mem_x8_untouched", mem[8], 32'h0000_0000);
        chk("mem_x14", mem[14], 32'h0000_0002);

        // Abort during the write cycle, before the committing edge
        @(negedge clk);
        req_valid = 1'b1;
        rs1 = 5'd1; rd = 5'd15; imm = 12'h001; funct3 = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!rf_write && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("abort_reached_write", {31'd0, rf_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rf_write_drop", {31'd0, rf_write}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("abort_x15_unchanged", mem[15], 32'h0000_DEAD);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_result", result, 32'd0);
        chk("post_rst_x15", mem[15], 32'h0000_DEAD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i_type_rf_sequencer.md
Name: i_type_rf_sequencer

Overview:
- Initiator-side controller for the single-port register file used by the I-type datapath.
- Accepts one decoded I-type ALU instruction (rs1, rd, imm, funct3) through a valid/ready handshake. Reads rs1 through the register file's address/write/out interface, computes the immediate ALU result, then writes it back to rd.
- Owns every register-file access cycle: address, write strobe and write data.

Parameters:
- XLEN, 32, data width of register-file words and ALU result.
- AW, 5, register address width (32 architectural registers).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  instruction available.
- req_ready  output  1  sequencer can accept an instruction (high only in IDLE).
- rs1  input  AW  source register; sampled on acceptance.
- rd  input  AW  destination register; sampled on acceptance.
- imm  input  12  sign-extended I-type immediate; sampled on acceptance.
- funct3  input  3  operation select; sampled on acceptance.
- rf_address  output  AW  register-file address.
- rf_write  output  1  register-file write strobe (1 = write, 0 = read).
- rf_wdata  output  XLEN  register-file write data.
- rf_rdata  input  XLEN  registered register-file read data; valid the cycle after a read address is presented.
- done  output  1  one-cycle pulse: instruction retired.
- result  output  XLEN  last computed result; held until the next retirement.
- illegal  output  1  qualifies done: the instruction was an illegal encoding and no write occurred.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; req_ready=1; rf_write=0; rf_address=0; rf_wdata=0; done=0; result=0; illegal=0. Reset mid-instruction aborts immediately, and rf_write drops without waiting for a clock edge.
- Acceptance: req_valid & req_ready at a rising edge. rs1/rd/imm/funct3 are latched; state goes to READ.
- States:
  - IDLE: req_ready=1; rf_write=0.
  - READ: rf_address=rs1_q; rf_write=0; the register file loads its output at the end of this cycle. Go to CAPT.
  - CAPT: operand=rf_rdata. Compute and register the result; decode legality. Go to WRITE if legal and rd_q!=0, else go to IDLE with done=1.
  - WRITE: rf_address=rd_q; rf_write=1; rf_wdata=result_q. The write commits at the end of this cycle. Go to IDLE.
- done: pulses for exactly 1 cycle, the first IDLE cycle after retirement. req_ready is also 1 in that cycle, so back-to-back acceptance is allowed.
- Latency, acceptance edge to done:
  - 4 cycles for a legal op with rd!=0.
  - 3 cycles for rd=0 or an illegal op.
- ALU rules (imm sign-extended to XLEN):
  - 000 ADDI: add, wraps modulo 2^XLEN.
  - 010 SLTI: signed compare, result 1/0.
  - 011 SLTIU: unsigned compare, result 1/0.
  - 100 XORI, 110 ORI, 111 ANDI: bitwise.
  - 001 SLLI: legal only if imm[11:5]=0; shift amount imm[4:0].
  - 101 SRLI if imm[11:5]=0000000, SRAI if imm[11:5]=0100000; any other imm[11:5] is illegal.
- x0 handling: rd=0 means no write cycle is issued (the register file does not hardwire x0). result still updates; illegal=0.
- Illegal encoding: no write; done=1 with illegal=1; result unchanged.
- req_valid while busy: ignored; inputs are not sampled.
- rf_write must never be 1 outside the WRITE state.

Decomposition:
- Shared package (i_type_pkg):
  - state enum IDLE/READ/CAPT/WRITE;
  - funct3 constants F3_ADDI, F3_SLLI, F3_SLTI, F3_SLTIU, F3_XORI, F3_SRXI, F3_ORI, F3_ANDI;
  - constants FUNCT7_ZERO=7'b0000000 and FUNCT7_SRA=7'b0100000.
- One sub-module, i_type_alu: combinational (operand, imm, funct3) -> (result, legal). It is reused by the later pipelined datapath.

Test Plan:
- Preload x1=0x00000005. Issue ADDI rs1=1, rd=2, imm=0xFFD (-3) -> rf_write=1 with address 2 and wdata 0x00000002 exactly 3 cycles after acceptance; done 4 cycles after acceptance; result=0x00000002.
- x3=0x80000000. Issue SRAI rs1=3, rd=4, imm=0x41F -> x4=0xFFFFFFFF. Then SRLI with imm=0x01F -> 0x00000001.
- x5=0xFFFFFFFF. Issue SLTI imm=0x001 -> 1; SLTIU imm=0x001 -> 0. Both are back-to-back: the second is accepted in the same cycle as the first done.
- ADDI rd=0, imm=0x123 -> no rf_write pulse ever; done after 3 cycles; result=0x00000123+x(rs1); illegal=0.
- SLLI imm=0x420 (illegal funct7) -> no write; done=1 with illegal=1; result holds its previous value.
- Assert rst_n=0 asynchronously during the WRITE cycle, before the clock edge -> rf_write drops immediately and the destination register is unchanged. After release: req_ready=1, done=0, result=0.
